// File: rtl/desired_drive_pipe_if.sv
// Handshake and data bundle for desired_drive_pipe.
// The master drives samples and out_rdy; the slave is the pipeline.
interface desired_drive_pipe_if #(
    parameter int unsigned TORQUE_W = 12,
    parameter int unsigned OUT_W    = 12
);
    logic                 in_vld;
    logic                 in_rdy;
    logic [TORQUE_W-1:0]  avg_torque;
    logic [4:0]           cadence;
    logic                 not_pedaling;
    logic signed [12:0]   incline;
    logic [2:0]           scale;
    logic                 out_vld;
    logic                 out_rdy;
    logic [OUT_W-1:0]     target_curr;

    modport master (
        output in_vld, avg_torque, cadence, not_pedaling, incline, scale, out_rdy,
        input  in_rdy, out_vld, target_curr
    );

    modport slave (
        input  in_vld, avg_torque, cadence, not_pedaling, incline, scale, out_rdy,
        output in_rdy, out_vld, target_curr
    );
endinterface

// File: rtl/desired_drive_pipe.sv
// Three-stage pipeline turning pedal torque, cadence, incline and assist level into a
// motor current target, with optional slew limiting and a global stall on backpressure.
module desired_drive_pipe #(
    parameter int unsigned          TORQUE_W   = 12,
    parameter int unsigned          OUT_W      = 12,
    parameter logic [TORQUE_W-1:0]  TORQUE_MIN = TORQUE_W'(12'h380),
    parameter bit                   SLEW_EN    = 1'b1,
    parameter logic [OUT_W-1:0]     SLEW_STEP  = OUT_W'(16)
) (
    input logic                  clk,
    input logic                  rst_n,
    desired_drive_pipe_if.slave  bus
);
    localparam int unsigned PROD_W = TORQUE_W + 18;
    localparam int unsigned SHIFT  = PROD_W - OUT_W - 3;

    logic advance;

    // Stage 1 state
    logic                s1_vld_q;
    logic [TORQUE_W-1:0] s1_torque_q;
    logic [8:0]          s1_incline_q;
    logic [5:0]          s1_cad_q;
    logic [2:0]          s1_scale_q;
    logic                s1_np_q;

    // Stage 2 state
    logic                s2_vld_q;
    logic [PROD_W-1:0]   s2_prod_q;
    logic                s2_np_q;

    // Stage 3 state
    logic                out_vld_q;
    logic [OUT_W-1:0]    target_q;

    // Stage 1 combinational factors
    logic signed [12:0]  incline_sat;
    logic signed [13:0]  incline_factor;
    logic [8:0]          incline_lim_d;
    logic [5:0]          cad_fac_d;
    logic [TORQUE_W-1:0] torque_pos_d;

    logic [PROD_W-1:0]   prod_d;
    logic [OUT_W-1:0]    target_raw;
    logic [OUT_W-1:0]    target_d;
    logic [OUT_W-1:0]    slew_diff;
    logic                unused_prod_lo;

    // Any stall freezes every stage at once, so a single advance covers the whole pipe.
    assign advance         = !out_vld_q || bus.out_rdy;
    assign bus.in_rdy      = advance;
    assign bus.out_vld     = out_vld_q;
    assign bus.target_curr = target_q;

    always_comb begin
        incline_sat = bus.incline;
        if (bus.incline < -13'sd512) begin
            incline_sat = -13'sd512;
        end else if (bus.incline > 13'sd511) begin
            incline_sat = 13'sd511;
        end
        incline_factor = {incline_sat[12], incline_sat} + 14'sd256;
        if (incline_factor < 14'sd0) begin
            incline_lim_d = 9'd0;
        end else if (incline_factor > 14'sd511) begin
            incline_lim_d = 9'd511;
        end else begin
            incline_lim_d = incline_factor[8:0];
        end

        cad_fac_d = (bus.cadence > 5'd1) ? ({1'b0, bus.cadence} + 6'd32) : 6'd0;
        torque_pos_d = (bus.avg_torque >= TORQUE_MIN) ? (bus.avg_torque - TORQUE_MIN) : '0;
    end

    always_comb begin
        if (s1_np_q) begin
            prod_d = '0;
        end else begin
            prod_d = PROD_W'(s1_torque_q) * PROD_W'(s1_incline_q)
                   * PROD_W'(s1_cad_q) * PROD_W'(s1_scale_q);
        end
    end

    assign unused_prod_lo = ^s2_prod_q[SHIFT-1:0];

    always_comb begin
        target_raw = (|s2_prod_q[PROD_W-1:PROD_W-3]) ? '1 : s2_prod_q[SHIFT+OUT_W-1:SHIFT];
        slew_diff  = '0;
        if (!SLEW_EN) begin
            target_d = target_raw;
        end else if (s2_np_q) begin
            target_d = '0;
        end else if (target_raw >= target_q) begin
            slew_diff = target_raw - target_q;
            target_d  = (slew_diff > SLEW_STEP) ? (target_q + SLEW_STEP) : target_raw;
        end else begin
            slew_diff = target_q - target_raw;
            target_d  = (slew_diff > SLEW_STEP) ? (target_q - SLEW_STEP) : target_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s1_torque_q  <= '0;
            s1_incline_q <= '0;
            s1_cad_q     <= '0;
            s1_scale_q   <= '0;
            s1_np_q      <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_prod_q    <= '0;
            s2_np_q      <= 1'b0;
            out_vld_q    <= 1'b0;
            target_q     <= '0;
        end else if (advance) begin
            s1_vld_q     <= bus.in_vld;
            s1_torque_q  <= torque_pos_d;
            s1_incline_q <= incline_lim_d;
            s1_cad_q     <= cad_fac_d;
            s1_scale_q   <= bus.scale;
            s1_np_q      <= bus.not_pedaling;
            s2_vld_q     <= s1_vld_q;
            s2_prod_q    <= prod_d;
            s2_np_q      <= s1_np_q;
            // A bubble reaching S3 clears out_vld but leaves the last target in place.
            out_vld_q    <= s2_vld_q;
            if (s2_vld_q) begin
                target_q <= target_d;
            end
        end
    end
endmodule

// File: tb/tb_desired_drive_pipe.sv
// Scoreboard bench: two pipelines (slew off / slew on) share one stimulus stream and are
// checked against an arithmetic reference model of the drive target.
module tb_desired_drive_pipe;
    localparam int TMIN = 'h380;
    localparam int STEP = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_vld = 1'b0;
    logic [11:0]        avg_torque = '0;
    logic [4:0]         cadence = '0;
    logic               not_pedaling = 1'b0;
    logic signed [12:0] incline = '0;
    logic [2:0]         scale = '0;
    logic               out_rdy = 1'b1;

    always #5 clk = ~clk;

    desired_drive_pipe_if #(.TORQUE_W(12), .OUT_W(12)) bus0 ();
    desired_drive_pipe_if #(.TORQUE_W(12), .OUT_W(12)) bus1 ();

    assign bus0.in_vld = in_vld;        assign bus1.in_vld = in_vld;
    assign bus0.avg_torque = avg_torque; assign bus1.avg_torque = avg_torque;
    assign bus0.cadence = cadence;      assign bus1.cadence = cadence;
    assign bus0.not_pedaling = not_pedaling; assign bus1.not_pedaling = not_pedaling;
    assign bus0.incline = incline;      assign bus1.incline = incline;
    assign bus0.scale = scale;          assign bus1.scale = scale;
    assign bus0.out_rdy = out_rdy;      assign bus1.out_rdy = out_rdy;

    desired_drive_pipe #(.SLEW_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    desired_drive_pipe #(.SLEW_EN(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int n_out0 = 0;
    int last_t0 = 0;
    int last_t1 = 0;
    int cur1 = 0;
    int last_acc_cyc = 0;
    int q0[$];
    int q1[$];
    int t1_hist[$];
    bit rnd_rdy_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int raw_model(input int t, input int c, input bit np, input int inc,
                                     input int s);
        int     isat, f, cf, tp;
        longint p;
        isat = (inc < -512) ? -512 : (inc > 511) ? 511 : inc;
        f    = isat + 256;
        f    = (f < 0) ? 0 : (f > 511) ? 511 : f;
        cf   = (c > 1) ? c + 32 : 0;
        tp   = (t >= TMIN) ? t - TMIN : 0;
        p    = longint'(tp) * f * cf * s;
        if (np) p = 0;
        if (p >= (longint'(1) << 27)) return 4095;
        return int'((p >> 15) & 4095);
    endfunction

    task automatic push(input int t, input int c, input bit np, input int inc, input int s);
        int r;
        int d;
        r = raw_model(t, c, np, inc, s);
        q0.push_back(r);
        if (np) begin
            cur1 = 0;
        end else begin
            d = (r > cur1) ? r - cur1 : cur1 - r;
            if (d > STEP) d = STEP;
            cur1 = (r > cur1) ? cur1 + d : cur1 - d;
        end
        q1.push_back(cur1);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the sample.
    task automatic send(input int t, input int c, input bit np, input int inc, input int s);
        bit acc = 1'b0;
        in_vld = 1'b1;
        avg_torque = 12'(t);
        cadence = 5'(c);
        not_pedaling = np;
        incline = 13'(inc);
        scale = 3'(s);
        for (int k = 0; k < 1000 && !acc; k++) begin
            @(negedge clk);
            if (bus0.in_rdy) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
                push(t, c, np, inc, s);
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_rdy stuck at 0, required 1 within 1000 cycles");
        end
    endtask

    task automatic send_random();
        int t, c, inc;
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h3ff))
                                        : int'($urandom_range(0, 'hfff));
        c = int'($urandom_range(0, 31));
        inc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 8191)) - 4096
                                          : int'($urandom_range(0, 1200)) - 600;
        send(t, c, ($urandom_range(0, 7) == 0), inc, int'($urandom_range(0, 7)));
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
        #1;
        check("drain_q0_left", q0.size(), 0);
        check("drain_q1_left", q1.size(), 0);
    endtask

    // Monitor: pops the expected result whenever a DUT output is consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.out_vld && out_rdy) begin
                if (q0.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out0: got 0x%0h, required no output",
                             bus0.target_curr);
                end else begin
                    check("target0", int'(bus0.target_curr), q0.pop_front());
                end
                last_t0 = int'(bus0.target_curr);
                n_out0++;
            end
            if (bus1.out_vld && out_rdy) begin
                if (q1.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out1: got 0x%0h, required no output",
                             bus1.target_curr);
                end else begin
                    check("target1", int'(bus1.target_curr), q1.pop_front());
                end
                last_t1 = int'(bus1.target_curr);
                t1_hist.push_back(last_t1);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy_en) begin
            #1;
            out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion by 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int h0, h1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_out_vld0", bus0.out_vld, 0);
        check("rst_out_vld1", bus1.out_vld, 0);
        check("rst_target0", bus0.target_curr, 0);
        check("rst_target1", bus1.target_curr, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        check("rst_in_rdy", bus0.in_rdy, 1);

        // Nominal sample: latency and value, then slew ramp to 0x600.
        send('h780, 16, 1'b0, 0, 4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus0.out_vld) break;
        end
        check("latency", cyc - last_acc_cyc, 3);
        check("nominal_target0", bus0.target_curr, 'h600);
        check("slew_first_step", bus1.target_curr, 'h010);
        @(posedge clk); #1;
        for (int i = 0; i < 99; i++) send('h780, 16, 1'b0, 0, 4);
        drain();
        check("slew_out2", t1_hist[1], 'h020);
        check("slew_out95", t1_hist[94], 'h5f0);
        check("slew_out96", t1_hist[95], 'h600);
        check("slew_hold", last_t1, 'h600);
        send('h780, 16, 1'b1, 0, 4);
        drain();
        check("np_zero_slew", last_t1, 0);
        check("np_zero_noslew", last_t0, 0);

        // Saturation and zero corners.
        send('hfff, 31, 1'b0, 256, 7);   drain(); check("saturate", last_t0, 'hfff);
        send('h780, 1, 1'b0, 0, 4);      drain(); check("cadence1", last_t0, 0);
        send('h37f, 16, 1'b0, 0, 4);     drain(); check("torque_min", last_t0, 0);
        send('h780, 16, 1'b0, -300, 4);  drain(); check("incline_neg", last_t0, 0);

        // Random traffic with random backpressure.
        rnd_rdy_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_random();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_rdy_en = 1'b0;
        @(posedge clk); #1 out_rdy = 1'b1;
        drain();

        // Back-to-back stream with a 5-cycle consumer stall.
        n0 = n_out0;
        fork
            for (int i = 0; i < 10; i++) send_random();
            begin
                repeat (5) @(posedge clk);
                #1 out_rdy = 1'b0;
                @(negedge clk);
                h0 = int'(bus0.target_curr);
                h1 = int'(bus1.target_curr);
                check("stall_in_rdy", bus0.in_rdy, 0);
                check("stall_out_vld", bus0.out_vld, 1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("stall_in_rdy", bus0.in_rdy, 0);
                    check("stall_hold0", bus0.target_curr, h0);
                    check("stall_hold1", bus1.target_curr, h1);
                end
                @(posedge clk); #1 out_rdy = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out0 - n0, 10);

        // Reset with samples in flight.
        n0 = n_out0;
        send('h900, 20, 1'b0, 100, 5);
        send('h780, 16, 1'b0, 0, 4);
        send('hfff, 31, 1'b0, 256, 7);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        t1_hist.delete();
        cur1 = 0;
        #1;
        check("midrst_out_vld0", bus0.out_vld, 0);
        check("midrst_out_vld1", bus1.out_vld, 0);
        check("midrst_target0", bus0.target_curr, 0);
        check("midrst_target1", bus1.target_curr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_stale_output", n_out0 - n0, 0);
        send('h780, 16, 1'b0, 0, 4);
        drain();
        check("post_rst_slew", last_t1, 'h010);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
